if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage.
- Owns the PC register, selects the next PC (sequential, branch redirect, flush/exception entry) and drives the instruction SRAM read port.
- Presents pc_valid, fs_to_ds_bus (PC) and csr_vec_h (fetch exception vector) to decode. Decode samples the SRAM read data one cycle after the address is issued.
- Remembers a branch redirect that arrives while IF is stalled.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset
FS_TO_DS_BUS_WD, 32, width of fs_to_ds_bus (PC only)
BR_BUS_WD, 33, width of br_bus {br_taken, br_target}

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  exception/ertn redirect, highest priority
new_pc  input  32  redirect target when flush=1
stall  input  6  pipeline stall vector; stall[0]=IF hold
br_bus  input  33  {br_taken[32], br_target[31:0]} from execute
inst_sram_en  output  1  SRAM read enable
inst_sram_we  output  4  byte write enables, constant 0
inst_sram_addr  output  32  fetch address
inst_sram_wdata  output  32  constant 0
pc_valid  output  1  fetched slot holds a real instruction
fs_to_ds_bus  output  32  PC of fetched slot
csr_vec_h  output  32  fetch exception vector; bit0=ADEF, bits[31:1]=0

Behaviour:
- State:
  - pc_r: 32-bit PC register.
  - valid_r: 1-bit valid flag.
  - pend_r / pend_tgt_r: 1+32-bit pending-branch store.
- Reset: pc_r=RESET_PC-4, valid_r=0, pend_r=0, pend_tgt_r=0.
- Outputs during reset: inst_sram_en=0, pc_valid=0, fs_to_ds_bus=RESET_PC-4, csr_vec_h=0.
- next_pc priority:
  1. flush -> new_pc
  2. br_taken -> br_target
  3. pend_r -> pend_tgt_r
  4. otherwise pc_r+4
- Adder wraps modulo 2^32: 0xfffffffc+4=0.
- Update rule:
  - flush=1: pc_r<=new_pc, valid_r<=1, pend_r<=0, regardless of stall.
  - Else stall[0]=0: pc_r<=next_pc, valid_r<=1, pend_r<=0.
  - Else (stall[0]=1): pc_r and valid_r hold.
- Pending branch:
  - If stall[0]=1 and br_taken=1 and flush=0: pend_r<=1, pend_tgt_r<=br_target.
  - A later br_taken during the same stall overwrites pend_tgt_r.
  - pend_r is consumed on the first non-stalled edge.
- Read port:
  - inst_sram_addr=pc_r.
  - inst_sram_en=valid_r & ~adef.
  - Address and enable are held constant while stalled, so read data stays stable for decode.
- adef = (pc_r[1:0]!=0).
- Decode-facing outputs:
  - csr_vec_h = {31'b0, valid_r & adef}.
  - pc_valid = valid_r.
  - fs_to_ds_bus = pc_r.
- Wrong-path squash is done by decode via br_taken; IF takes no squash action for the slot in flight.
- Latency: one cycle from a redirect (flush or unstalled branch) to the target appearing on inst_sram_addr.
- Simultaneous events:
  - flush & br_taken: flush wins, branch discarded.
  - flush & stall[0]: flush wins.
  - br_taken & pend_r (unstalled): br_taken wins, pend cleared.
- Reset mid-stall or with pending branch: all state returns to reset values next edge.

Test Plan:
- Reset 3 cycles, release, no stall -> addr 0x1c000000 then 0x1c000004 then 0x1c000008 on consecutive cycles; pc_valid=1 from the first cycle after release; en=1.
- Unstalled br_bus={1,0x1c000100} with pc_r=0x1c000010 -> next cycle addr=0x1c000100; following cycle 0x1c000104.
- stall[0]=1 for 3 cycles; br_taken=1 target 0x1c000200 in cycle 1; release -> addr held at the pre-stall value throughout the stall, then 0x1c000200, then 0x1c000204; pend_r cleared.
- flush=1 new_pc=0x1c008000 while stall[0]=1 and br_taken=1 target 0x1c000300 -> next cycle addr=0x1c008000; pend_r=0.
- Misaligned: flush new_pc=0x1c000002 -> addr=0x1c000002; inst_sram_en=0; csr_vec_h=32'h1; pc_valid=1.
- Reset asserted while pend_r=1 -> pc_r=RESET_PC-4, pend_r=0, en=0; first fetch after release at 0x1c000000.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage port bundle: redirect/stall/branch inputs from the pipeline,
// instruction SRAM read port and decode-facing slot outputs.
interface if_stage_if #(
  parameter int FS_TO_DS_BUS_WD = 32,
  parameter int BR_BUS_WD       = 33
);
  // Flow control: there is no valid/ready pair here. A fetched slot is
  // meaningful to decode only while pc_valid=1; stall[0]=1 freezes the slot,
  // holding inst_sram_addr/inst_sram_en so the SRAM read data stays stable.
  // flush overrides stall and takes effect on the next edge.
  logic                       flush;
  logic [31:0]                new_pc;
  logic [5:0]                 stall;
  logic [BR_BUS_WD-1:0]       br_bus;

  logic                       inst_sram_en;
  logic [3:0]                 inst_sram_we;
  logic [31:0]                inst_sram_addr;
  logic [31:0]                inst_sram_wdata;

  logic                       pc_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic [31:0]                csr_vec_h;

  logic                       dbg_pend;
  logic [31:0]                dbg_pend_tgt;

  modport master (
    input  flush, new_pc, stall, br_bus,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output pc_valid, fs_to_ds_bus, csr_vec_h,
    output dbg_pend, dbg_pend_tgt
  );

  modport slave (
    output flush, new_pc, stall, br_bus,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  pc_valid, fs_to_ds_bus, csr_vec_h,
    input  dbg_pend, dbg_pend_tgt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address and
// remembers a taken branch that arrives while fetch is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          FS_TO_DS_BUS_WD = 32,
  parameter int          BR_BUS_WD       = 33
) (
  input  logic          clk,
  input  logic          reset,
  if_stage_if.master    fs
);

  logic        pc_valid_unused;
  logic [31:0] pc_r;
  logic        valid_r;
  logic        pend_r;
  logic [31:0] pend_tgt_r;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        adef;

  assign br_taken  = fs.br_bus[32];
  assign br_target = fs.br_bus[31:0];
  assign adef      = (pc_r[1:0] != 2'b00);
  assign pc_valid_unused = 1'b0;

  // Priority below flush: a fresh branch beats a remembered one.
  always_comb begin
    next_pc = pc_r + 32'd4;
    if (br_taken)
      next_pc = br_target;
    else if (pend_r)
      next_pc = pend_tgt_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= RESET_PC - 32'd4;
      valid_r    <= 1'b0;
      pend_r     <= 1'b0;
      pend_tgt_r <= 32'd0;
    end else if (fs.flush) begin
      pc_r    <= fs.new_pc;
      valid_r <= 1'b1;
      pend_r  <= 1'b0;
    end else if (!fs.stall[0]) begin
      pc_r    <= next_pc;
      valid_r <= 1'b1;
      pend_r  <= 1'b0;
    end else if (br_taken) begin
      // Stalled: keep the slot frozen, park the redirect for later.
      pend_r     <= 1'b1;
      pend_tgt_r <= br_target;
    end
  end

  assign fs.inst_sram_en    = valid_r & ~adef;
  assign fs.inst_sram_we    = 4'b0000;
  assign fs.inst_sram_addr  = pc_r;
  assign fs.inst_sram_wdata = 32'd0;

  assign fs.pc_valid     = valid_r;
  assign fs.fs_to_ds_bus = FS_TO_DS_BUS_WD'(pc_r);
  assign fs.csr_vec_h    = {31'd0, valid_r & adef};

  assign fs.dbg_pend     = pend_r;
  assign fs.dbg_pend_tgt = pend_tgt_r;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan steps followed by random traffic,
// all checked each cycle against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_stage_if bus_if ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .fs    (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];

  // Reference model: architectural view of fetch state.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_pend;
  logic [31:0] m_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit fl, input logic [31:0] npc,
                       input logic [5:0] st, input bit br, input logic [31:0] tgt);
    reset         = rst;
    bus_if.flush  = fl;
    bus_if.new_pc = npc;
    bus_if.stall  = st;
    bus_if.br_bus = {br, tgt};
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = RESET_PC - 32'd4; m_valid = 1'b0; m_pend = 1'b0; m_tgt = 32'd0;
    end else if (bus_if.flush) begin
      m_pc = bus_if.new_pc; m_valid = 1'b1; m_pend = 1'b0;
    end else if (!bus_if.stall[0]) begin
      if (bus_if.br_bus[32])  m_pc = bus_if.br_bus[31:0];
      else if (m_pend)        m_pc = m_tgt;
      else                    m_pc = m_pc + 32'd4;
      m_valid = 1'b1; m_pend = 1'b0;
    end else if (bus_if.br_bus[32]) begin
      m_pend = 1'b1; m_tgt = bus_if.br_bus[31:0];
    end
  endtask

  task automatic check_all();
    bit misaligned;
    misaligned = (m_pc % 4) != 0;
    chk("addr",     bus_if.inst_sram_addr, m_pc);
    chk("en",       32'(bus_if.inst_sram_en), 32'(m_valid && !misaligned));
    chk("we",       32'(bus_if.inst_sram_we), 32'd0);
    chk("wdata",    bus_if.inst_sram_wdata, 32'd0);
    chk("pc_valid", 32'(bus_if.pc_valid), 32'(m_valid));
    chk("fs_bus",   bus_if.fs_to_ds_bus, m_pc);
    chk("csr_vec",  bus_if.csr_vec_h, (m_valid && misaligned) ? 32'd1 : 32'd0);
    chk("pend",     32'(bus_if.dbg_pend), 32'(m_pend));
    if (m_pend)
      chk("pend_tgt", bus_if.dbg_pend_tgt, m_tgt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] tgt;
    logic [5:0]  st;
    bit          rst, fl, br;

    // Reset for three cycles.
    drive(1, 0, 0, 6'd0, 0, 0);
    repeat (3) tick();
    chk("rst_en",    32'(bus_if.inst_sram_en), 32'd0);
    chk("rst_valid", 32'(bus_if.pc_valid), 32'd0);
    chk("rst_addr",  bus_if.inst_sram_addr, 32'h1bfffffc);
    chk("rst_csr",   bus_if.csr_vec_h, 32'd0);

    // Sequential fetch after release.
    drive(0, 0, 0, 6'd0, 0, 0);
    exp_q.push_back(32'h1c000000);
    exp_q.push_back(32'h1c000004);
    exp_q.push_back(32'h1c000008);
    while (exp_q.size() > 0) begin
      tick();
      chk("seq_addr",  bus_if.inst_sram_addr, exp_q.pop_front());
      chk("seq_valid", 32'(bus_if.pc_valid), 32'd1);
      chk("seq_en",    32'(bus_if.inst_sram_en), 32'd1);
    end
    repeat (2) tick();
    chk("pre_br_addr", bus_if.inst_sram_addr, 32'h1c000010);

    // Unstalled branch.
    drive(0, 0, 0, 6'd0, 1, 32'h1c000100);
    tick();
    chk("br_addr", bus_if.inst_sram_addr, 32'h1c000100);
    drive(0, 0, 0, 6'd0, 0, 0);
    tick();
    chk("br_next", bus_if.inst_sram_addr, 32'h1c000104);

    // Branch during a three-cycle stall is remembered.
    drive(0, 0, 0, 6'b000001, 1, 32'h1c000200);
    tick();
    chk("stall_hold1", bus_if.inst_sram_addr, 32'h1c000104);
    drive(0, 0, 0, 6'b000011, 0, 0);
    repeat (2) tick();
    chk("stall_hold3", bus_if.inst_sram_addr, 32'h1c000104);
    chk("stall_pend",  32'(bus_if.dbg_pend), 32'd1);
    drive(0, 0, 0, 6'd0, 0, 0);
    tick();
    chk("pend_addr", bus_if.inst_sram_addr, 32'h1c000200);
    chk("pend_clr",  32'(bus_if.dbg_pend), 32'd0);
    tick();
    chk("pend_next", bus_if.inst_sram_addr, 32'h1c000204);

    // Flush beats stall and branch.
    drive(0, 1, 32'h1c008000, 6'b000001, 1, 32'h1c000300);
    tick();
    chk("flush_addr", bus_if.inst_sram_addr, 32'h1c008000);
    chk("flush_pend", 32'(bus_if.dbg_pend), 32'd0);

    // Misaligned redirect raises ADEF.
    drive(0, 1, 32'h1c000002, 6'd0, 0, 0);
    tick();
    chk("adef_addr",  bus_if.inst_sram_addr, 32'h1c000002);
    chk("adef_en",    32'(bus_if.inst_sram_en), 32'd0);
    chk("adef_csr",   bus_if.csr_vec_h, 32'd1);
    chk("adef_valid", 32'(bus_if.pc_valid), 32'd1);

    // Address wrap.
    drive(0, 1, 32'hfffffffc, 6'd0, 0, 0);
    tick();
    drive(0, 0, 0, 6'd0, 0, 0);
    tick();
    chk("wrap_addr", bus_if.inst_sram_addr, 32'h00000000);

    // Reset while a branch is pending.
    drive(0, 0, 0, 6'b000001, 1, 32'h1c000400);
    tick();
    chk("pre_rst_pend", 32'(bus_if.dbg_pend), 32'd1);
    drive(1, 0, 0, 6'b000001, 0, 0);
    tick();
    chk("rst_pend_addr", bus_if.inst_sram_addr, 32'h1bfffffc);
    chk("rst_pend_clr",  32'(bus_if.dbg_pend), 32'd0);
    chk("rst_pend_en",   32'(bus_if.inst_sram_en), 32'd0);
    drive(0, 0, 0, 6'd0, 0, 0);
    tick();
    chk("rst_first", bus_if.inst_sram_addr, 32'h1c000000);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 4) == 0);
      st  = 6'($urandom_range(0, 63));
      st[0] = ($urandom_range(0, 9) < 4);
      tgt = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 19) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) tgt = 32'hfffffffc;
      drive(rst, fl, tgt ^ 32'h00010000, st, br, tgt);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
